// File: rtl/ttw_mem_trk_pkg.sv
// Shared types for the table-walk miss tracker: walker/slot/line widths and
// the per-slot state encoding.
package ttw_mem_trk_pkg;
  localparam int TTW_N = 4;
  localparam int TTW_W = $clog2(TTW_N);
  localparam int SLT_N = 4;
  localparam int SLT_W = $clog2(SLT_N);
  localparam int MCN_W = 58;
  localparam int DAT_W = 512;

  typedef logic [TTW_W-1:0] ttw_t;
  typedef logic [SLT_W-1:0] slt_t;
  typedef logic [MCN_W-1:0] mcn_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ISSD, ST_RESP} slt_st_e;
endpackage

// File: rtl/ttw_mem_pri.sv
// Lowest-set-bit priority encoder; o_idx is 0 when nothing is requested.
module ttw_mem_pri #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  output logic         o_vld,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_idx = W'(i);
  end
endmodule

// File: rtl/ttw_mem_trk.sv
// Miss tracker: merges same-line walker reads into one memory read per slot
// and fans the returned line back out to every waiting walker.
module ttw_mem_trk #(
  parameter int TTW_N = ttw_mem_trk_pkg::TTW_N,
  parameter int SLT_N = ttw_mem_trk_pkg::SLT_N,
  parameter int MCN_W = ttw_mem_trk_pkg::MCN_W,
  parameter int DAT_W = ttw_mem_trk_pkg::DAT_W,
  parameter int TTW_W = $clog2(TTW_N),
  parameter int SLT_W = $clog2(SLT_N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_i_valid,
  output logic             req_i_ready,
  input  logic [TTW_W-1:0] req_i_bits_idx,
  input  logic [MCN_W-1:0] req_i_bits_mcn,
  output logic             res_o_valid,
  input  logic             res_o_ready,
  output logic [TTW_W-1:0] res_o_bits_idx,
  output logic [DAT_W-1:0] res_o_bits_data,
  output logic             mem_req_o_valid,
  input  logic             mem_req_o_ready,
  output logic [SLT_W-1:0] mem_req_o_bits_idx,
  output logic [MCN_W-1:0] mem_req_o_bits_mcn,
  input  logic             mem_res_i_valid,
  output logic             mem_res_i_ready,
  input  logic [SLT_W-1:0] mem_res_i_bits_idx,
  input  logic [DAT_W-1:0] mem_res_i_bits_data,
  output logic             busy_o
);
  import ttw_mem_trk_pkg::slt_st_e;
  import ttw_mem_trk_pkg::ST_IDLE;
  import ttw_mem_trk_pkg::ST_PEND;
  import ttw_mem_trk_pkg::ST_ISSD;
  import ttw_mem_trk_pkg::ST_RESP;

  slt_st_e          r_st     [SLT_N];
  slt_st_e          w_st_nxt [SLT_N];
  logic [TTW_N-1:0] r_wt     [SLT_N];
  logic [TTW_N-1:0] w_wt_nxt [SLT_N];
  logic [MCN_W-1:0] r_mcn    [SLT_N];
  logic [DAT_W-1:0] r_dat    [SLT_N];

  logic [SLT_N-1:0] w_idle, w_pend, w_resp, w_hit;
  logic             w_alloc_vld, w_merge, w_iss_vld, w_rs_vld, w_wk_vld;
  logic [SLT_W-1:0] w_alloc_slt, w_hit_slt, w_iss_slt, w_rs_slt;
  logic [TTW_W-1:0] w_wk_idx;
  logic [TTW_N-1:0] w_rs_wt, w_req_oh, w_wk_oh;
  logic             w_req_fire, w_iss_fire, w_res_fire;

  always_comb begin
    for (int s = 0; s < SLT_N; s++) begin
      w_idle[s] = (r_st[s] == ST_IDLE);
      w_pend[s] = (r_st[s] == ST_PEND);
      w_resp[s] = (r_st[s] == ST_RESP);
      w_hit[s]  = ((r_st[s] == ST_PEND) || (r_st[s] == ST_ISSD)) &&
                  (r_mcn[s] == req_i_bits_mcn);
    end
  end

  ttw_mem_pri #(.N(SLT_N), .W(SLT_W)) u_alloc (.i_req(w_idle), .o_vld(w_alloc_vld), .o_idx(w_alloc_slt));
  ttw_mem_pri #(.N(SLT_N), .W(SLT_W)) u_hit   (.i_req(w_hit),  .o_vld(w_merge),     .o_idx(w_hit_slt));
  ttw_mem_pri #(.N(SLT_N), .W(SLT_W)) u_iss   (.i_req(w_pend), .o_vld(w_iss_vld),   .o_idx(w_iss_slt));
  ttw_mem_pri #(.N(SLT_N), .W(SLT_W)) u_rsel  (.i_req(w_resp), .o_vld(w_rs_vld),    .o_idx(w_rs_slt));
  ttw_mem_pri #(.N(TTW_N), .W(TTW_W)) u_wsel  (.i_req(w_rs_wt), .o_vld(w_wk_vld),   .o_idx(w_wk_idx));

  assign w_rs_wt    = r_wt[w_rs_slt];
  assign w_req_oh   = TTW_N'(1) << req_i_bits_idx;
  assign w_wk_oh    = TTW_N'(1) << w_wk_idx;
  assign w_req_fire = req_i_valid & req_i_ready;
  assign w_iss_fire = w_iss_vld & mem_req_o_ready;
  assign w_res_fire = res_o_valid & res_o_ready;

  // Readiness depends only on registered slot state, never on the request line,
  // so a full tracker stalls even a request that could have merged.
  assign req_i_ready        = w_alloc_vld;
  assign mem_req_o_valid    = w_iss_vld;
  assign mem_req_o_bits_idx = w_iss_slt;
  assign mem_req_o_bits_mcn = w_iss_vld ? r_mcn[w_iss_slt] : '0;
  assign res_o_valid        = w_rs_vld & w_wk_vld;
  assign res_o_bits_idx     = res_o_valid ? w_wk_idx : '0;
  assign res_o_bits_data    = res_o_valid ? r_dat[w_rs_slt] : '0;
  assign mem_res_i_ready    = 1'b1;
  assign busy_o             = ~&w_idle;

  // Merge and allocate share the waiter-set path: an IDLE slot always holds wt==0.
  always_comb begin
    for (int s = 0; s < SLT_N; s++) begin
      w_st_nxt[s] = r_st[s];
      w_wt_nxt[s] = r_wt[s];
      if (w_req_fire && (w_merge ? (w_hit_slt == SLT_W'(s)) : (w_alloc_slt == SLT_W'(s))))
        w_wt_nxt[s] = r_wt[s] | w_req_oh;
      case (r_st[s])
        ST_IDLE: if (w_req_fire && !w_merge && (w_alloc_slt == SLT_W'(s))) w_st_nxt[s] = ST_PEND;
        ST_PEND: if (w_iss_fire && (w_iss_slt == SLT_W'(s))) w_st_nxt[s] = ST_ISSD;
        ST_ISSD: if (mem_res_i_valid && (mem_res_i_bits_idx == SLT_W'(s))) w_st_nxt[s] = ST_RESP;
        ST_RESP: if (w_res_fire && (w_rs_slt == SLT_W'(s))) begin
          w_wt_nxt[s] = r_wt[s] & ~w_wk_oh;
          if (w_wt_nxt[s] == '0) w_st_nxt[s] = ST_IDLE;
        end
        default: w_st_nxt[s] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < SLT_N; s++) begin
      if (reset) begin
        r_st[s] <= ST_IDLE;
        r_wt[s] <= '0;
      end else begin
        r_st[s] <= w_st_nxt[s];
        r_wt[s] <= w_wt_nxt[s];
      end
    end
  end

  // Payload registers need no reset: outputs are gated by slot state.
  always_ff @(posedge clock) begin
    for (int s = 0; s < SLT_N; s++) begin
      if ((r_st[s] == ST_IDLE) && (w_st_nxt[s] == ST_PEND)) r_mcn[s] <= req_i_bits_mcn;
      if ((r_st[s] == ST_ISSD) && (w_st_nxt[s] == ST_RESP)) r_dat[s] <= mem_res_i_bits_data;
    end
  end
endmodule

// File: tb/tb_ttw_mem_trk.sv
// Directed bench for ttw_mem_trk: single miss, merge, full, backpressure,
// out-of-order responses and reset mid-flight.
module tb_ttw_mem_trk;
  import ttw_mem_trk_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_i_valid = 1'b0;
  logic             req_i_ready;
  ttw_t             req_i_bits_idx = '0;
  mcn_t             req_i_bits_mcn = '0;
  logic             res_o_valid;
  logic             res_o_ready = 1'b0;
  ttw_t             res_o_bits_idx;
  logic [DAT_W-1:0] res_o_bits_data;
  logic             mem_req_o_valid;
  logic             mem_req_o_ready = 1'b0;
  slt_t             mem_req_o_bits_idx;
  mcn_t             mem_req_o_bits_mcn;
  logic             mem_res_i_valid = 1'b0;
  logic             mem_res_i_ready;
  slt_t             mem_res_i_bits_idx = '0;
  logic [DAT_W-1:0] mem_res_i_bits_data = '0;
  logic             busy_o;

  int checks = 0;
  int failures = 0;
  int mon_err = 0;
  logic allow_late = 1'b0;
  logic [TTW_N-1:0] m_out = '0;
  logic [SLT_N-1:0] m_iss = '0;

  localparam logic [DAT_W-1:0] D_A5 = {64{8'hA5}};
  localparam logic [DAT_W-1:0] D_3C = {64{8'h3C}};
  localparam logic [DAT_W-1:0] D_77 = {16{32'h7777_0001}};

  ttw_mem_trk dut (
    .clock(clock), .reset(reset),
    .req_i_valid(req_i_valid), .req_i_ready(req_i_ready),
    .req_i_bits_idx(req_i_bits_idx), .req_i_bits_mcn(req_i_bits_mcn),
    .res_o_valid(res_o_valid), .res_o_ready(res_o_ready),
    .res_o_bits_idx(res_o_bits_idx), .res_o_bits_data(res_o_bits_data),
    .mem_req_o_valid(mem_req_o_valid), .mem_req_o_ready(mem_req_o_ready),
    .mem_req_o_bits_idx(mem_req_o_bits_idx), .mem_req_o_bits_mcn(mem_req_o_bits_mcn),
    .mem_res_i_valid(mem_res_i_valid), .mem_res_i_ready(mem_res_i_ready),
    .mem_res_i_bits_idx(mem_res_i_bits_idx), .mem_res_i_bits_data(mem_res_i_bits_data),
    .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  // Protocol watchdog: duplicate walker idx, and responses to slots never issued.
  always @(posedge clock) begin
    if (reset) begin
      m_out <= '0;
      m_iss <= '0;
    end else begin
      if (req_i_valid && req_i_ready && m_out[req_i_bits_idx]) begin
        $display("FAIL dup_idx got idx=%0d outstanding, want unique idx", req_i_bits_idx);
        mon_err <= mon_err + 1;
      end
      if (mem_res_i_valid && !m_iss[mem_res_i_bits_idx] && !allow_late) begin
        $display("FAIL stray_mem_res got tag=%0d not issued, want issued tag", mem_res_i_bits_idx);
        mon_err <= mon_err + 1;
      end
      m_out <= (m_out | ((req_i_valid && req_i_ready) ? (TTW_N'(1) << req_i_bits_idx) : '0))
                      & ~((res_o_valid && res_o_ready) ? (TTW_N'(1) << res_o_bits_idx) : '0);
      m_iss <= (m_iss | ((mem_req_o_valid && mem_req_o_ready) ? (SLT_N'(1) << mem_req_o_bits_idx) : '0))
                      & ~(mem_res_i_valid ? (SLT_N'(1) << mem_res_i_bits_idx) : '0);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input int idx, input mcn_t mcn);
    req_i_valid = 1'b1; req_i_bits_idx = ttw_t'(idx); req_i_bits_mcn = mcn;
    tick;
    req_i_valid = 1'b0;
  endtask

  task automatic mem_resp(input int slt, input logic [DAT_W-1:0] d);
    mem_res_i_valid = 1'b1; mem_res_i_bits_idx = slt_t'(slt); mem_res_i_bits_data = d;
    tick;
    mem_res_i_valid = 1'b0;
  endtask

  task automatic issue(input int n);
    mem_req_o_ready = 1'b1;
    repeat (n) tick;
    mem_req_o_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    checks++;
    if ({req_i_ready, res_o_valid, mem_req_o_valid, busy_o, mem_res_i_ready} !== 5'b10001) begin
      $display("FAIL reset_ctrl got rdy,rv,mv,busy,mrdy=%b want 10001",
               {req_i_ready, res_o_valid, mem_req_o_valid, busy_o, mem_res_i_ready});
      failures++;
    end
    checks++;
    if ({res_o_bits_idx, res_o_bits_data, mem_req_o_bits_idx, mem_req_o_bits_mcn} !== '0) begin
      $display("FAIL reset_payload got ridx=%0d mslt=%0d mmcn=%h want all zero",
               res_o_bits_idx, mem_req_o_bits_idx, mem_req_o_bits_mcn);
      failures++;
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    send_req(1, 58'h1000);
    checks++;
    if ({mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn} !== {1'b1, 2'd0, 58'h1000}) begin
      $display("FAIL single_issue got v=%0b tag=%0d mcn=%h want v=1 tag=0 mcn=1000",
               mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn);
      failures++;
    end
    checks++;
    if (busy_o !== 1'b1) begin $display("FAIL single_busy got %0b want 1", busy_o); failures++; end
    issue(1);
    checks++;
    if ({mem_req_o_valid, res_o_valid} !== 2'b00) begin
      $display("FAIL single_issd got mv=%0b rv=%0b want 0 0", mem_req_o_valid, res_o_valid);
      failures++;
    end
    mem_resp(0, D_A5);
    checks++;
    if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'd1} || res_o_bits_data !== D_A5) begin
      $display("FAIL single_res got v=%0b idx=%0d data=%h want v=1 idx=1 data=a5..a5",
               res_o_valid, res_o_bits_idx, res_o_bits_data);
      failures++;
    end
    res_o_ready = 1'b1; tick; res_o_ready = 1'b0;
    checks++;
    if ({res_o_valid, busy_o} !== 2'b00) begin
      $display("FAIL single_done got rv=%0b busy=%0b want 0 0", res_o_valid, busy_o);
      failures++;
    end
  endtask

  task automatic test_merge;
    send_req(0, 58'h40);
    send_req(2, 58'h40);
    checks++;
    if ({mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn} !== {1'b1, 2'd0, 58'h40}) begin
      $display("FAIL merge_issue got v=%0b tag=%0d mcn=%h want v=1 tag=0 mcn=40",
               mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn);
      failures++;
    end
    issue(1);
    checks++;
    if (mem_req_o_valid !== 1'b0) begin
      $display("FAIL merge_one_read got mv=%0b want 0", mem_req_o_valid); failures++;
    end
    mem_resp(0, D_3C);
    res_o_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'(2 * k)} || res_o_bits_data !== D_3C) begin
        $display("FAIL merge_fanout%0d got v=%0b idx=%0d want v=1 idx=%0d data=3c..3c",
                 k, res_o_valid, res_o_bits_idx, 2 * k);
        failures++;
      end
      tick;
    end
    res_o_ready = 1'b0;
    checks++;
    if ({res_o_valid, busy_o} !== 2'b00) begin
      $display("FAIL merge_done got rv=%0b busy=%0b want 0 0", res_o_valid, busy_o); failures++;
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) send_req(i, mcn_t'((i + 1) * 'h100));
    req_i_valid = 1'b1; req_i_bits_idx = 2'd0; req_i_bits_mcn = 58'h100;
    checks++;
    if (req_i_ready !== 1'b0) begin $display("FAIL full_ready got %0b want 0", req_i_ready); failures++; end
    tick;
    checks++;
    if (req_i_ready !== 1'b0) begin $display("FAIL full_ready_hold got %0b want 0", req_i_ready); failures++; end
    req_i_valid = 1'b0;
    mem_req_o_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn} !== {1'b1, 2'(s), mcn_t'((s + 1) * 'h100)}) begin
        $display("FAIL full_issue%0d got v=%0b tag=%0d mcn=%h want v=1 tag=%0d", s,
                 mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn, s);
        failures++;
      end
      tick;
    end
    mem_req_o_ready = 1'b0;
    mem_resp(0, {16{32'hF0F0_0000}});
    checks++;
    if ({res_o_valid, res_o_bits_idx, req_i_ready} !== {1'b1, 2'd0, 1'b0}) begin
      $display("FAIL full_resp0 got rv=%0b idx=%0d rdy=%0b want 1 0 0", res_o_valid, res_o_bits_idx, req_i_ready);
      failures++;
    end
    res_o_ready = 1'b1; tick; res_o_ready = 1'b0;
    checks++;
    if ({req_i_ready, res_o_valid} !== 2'b10) begin
      $display("FAIL full_free got rdy=%0b rv=%0b want 1 0", req_i_ready, res_o_valid); failures++;
    end
    for (int s = 1; s < 4; s++) begin
      mem_resp(s, {16{32'(s)}});
      checks++;
      if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'(s)} || res_o_bits_data !== {16{32'(s)}}) begin
        $display("FAIL full_drain%0d got v=%0b idx=%0d want v=1 idx=%0d", s, res_o_valid, res_o_bits_idx, s);
        failures++;
      end
      res_o_ready = 1'b1; tick; res_o_ready = 1'b0;
    end
    checks++;
    if (busy_o !== 1'b0) begin $display("FAIL full_idle got busy=%0b want 0", busy_o); failures++; end
  endtask

  task automatic test_out_of_order;
    logic [DAT_W-1:0] dd [3];
    dd[0] = {64{8'hDA}}; dd[1] = {64{8'hDB}}; dd[2] = {64{8'hDC}};
    send_req(0, 58'hA00); send_req(1, 58'hB00); send_req(2, 58'hC00);
    issue(3);
    mem_resp(2, dd[2]);
    checks++;
    if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'd2} || res_o_bits_data !== dd[2]) begin
      $display("FAIL ooo_first got v=%0b idx=%0d want v=1 idx=2 data=dc..dc", res_o_valid, res_o_bits_idx);
      failures++;
    end
    mem_resp(0, dd[0]);
    mem_resp(1, dd[1]);
    res_o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'(k)} || res_o_bits_data !== dd[k]) begin
        $display("FAIL ooo_fanout%0d got v=%0b idx=%0d data=%h want v=1 idx=%0d", k,
                 res_o_valid, res_o_bits_idx, res_o_bits_data, k);
        failures++;
      end
      tick;
    end
    res_o_ready = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin $display("FAIL ooo_idle got busy=%0b want 0", busy_o); failures++; end
  endtask

  task automatic test_back_to_back;
    int exp_idx [3];
    exp_idx[0] = 1; exp_idx[1] = 2; exp_idx[2] = 3;
    send_req(3, 58'h77);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn} !== {1'b1, 2'd0, 58'h77}) begin
        $display("FAIL bp_mem_hold%0d got v=%0b tag=%0d mcn=%h want v=1 tag=0 mcn=77", c,
                 mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn);
        failures++;
      end
      tick;
    end
    // merge lands on the same edge as the PEND->ISSD issue
    req_i_valid = 1'b1; req_i_bits_idx = 2'd1; req_i_bits_mcn = 58'h77;
    mem_req_o_ready = 1'b1;
    tick;
    req_i_valid = 1'b0; mem_req_o_ready = 1'b0;
    checks++;
    if ({mem_req_o_valid, busy_o} !== 2'b01) begin
      $display("FAIL bp_issue_merge got mv=%0b busy=%0b want 0 1", mem_req_o_valid, busy_o); failures++;
    end
    // merge lands on the same edge as the memory response
    req_i_valid = 1'b1; req_i_bits_idx = 2'd2; req_i_bits_mcn = 58'h77;
    mem_resp(0, D_77);
    req_i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'd1} || res_o_bits_data !== D_77) begin
        $display("FAIL bp_res_hold%0d got v=%0b idx=%0d want v=1 idx=1", c, res_o_valid, res_o_bits_idx);
        failures++;
      end
      tick;
    end
    res_o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({res_o_valid, res_o_bits_idx} !== {1'b1, 2'(exp_idx[k])} || res_o_bits_data !== D_77) begin
        $display("FAIL bp_fanout%0d got v=%0b idx=%0d want v=1 idx=%0d", k, res_o_valid, res_o_bits_idx, exp_idx[k]);
        failures++;
      end
      tick;
    end
    res_o_ready = 1'b0;
    checks++;
    if ({res_o_valid, busy_o} !== 2'b00) begin
      $display("FAIL bp_done got rv=%0b busy=%0b want 0 0", res_o_valid, busy_o); failures++;
    end
  endtask

  task automatic test_reset_mid;
    send_req(0, 58'h10); send_req(1, 58'h20);
    issue(2);
    checks++;
    if ({busy_o, mem_req_o_valid} !== 2'b10) begin
      $display("FAIL rst_pre got busy=%0b mv=%0b want 1 0", busy_o, mem_req_o_valid); failures++;
    end
    reset = 1'b1; tick;
    checks++;
    if ({busy_o, req_i_ready, res_o_valid} !== 3'b010) begin
      $display("FAIL rst_in got busy,rdy,rv=%b want 010", {busy_o, req_i_ready, res_o_valid}); failures++;
    end
    reset = 1'b0;
    allow_late = 1'b1;
    mem_resp(0, D_A5);
    mem_resp(1, D_3C);
    allow_late = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({res_o_valid, busy_o} !== 2'b00) begin
        $display("FAIL rst_late%0d got rv=%0b busy=%0b want 0 0", c, res_o_valid, busy_o); failures++;
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_merge;
    test_full;
    test_out_of_order;
    test_back_to_back;
    test_reset_mid;
    tick;
    checks++;
    if (mon_err !== 0) begin
      $display("FAIL protocol_monitor got %0d violations want 0", mon_err); failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ttw_mem_trk.md
# ttw_mem_trk

Miss-tracking stage between the table-walk engines and the memory port. It accepts cache-line reads (`mcn`, a line number) tagged with a walker index. Concurrent requests to the same line are merged into one downstream read. The returned 512-bit line is fanned out to every waiting walker. It drives the memory request port directly and consumes the memory response port.

## Interface
Parameters:
- `TTW_N`, 4: number of walker indices; `TTW_W = $clog2(TTW_N)`.
- `SLT_N`, 4: tracker slots; `SLT_W = $clog2(SLT_N)`.
- `MCN_W`, 58: line-number width.
- `DAT_W`, 512: line width.

Ports:
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_i_valid` in 1: walker request valid.
- `req_i_ready` out 1: walker request ready.
- `req_i_bits_idx` in `TTW_W`: walker index.
- `req_i_bits_mcn` in `MCN_W`: line number requested.
- `res_o_valid` out 1: fan-out response valid.
- `res_o_ready` in 1: fan-out response ready.
- `res_o_bits_idx` out `TTW_W`: walker being answered.
- `res_o_bits_data` out `DAT_W`: line data for that walker.
- `mem_req_o_valid` out 1: downstream read valid.
- `mem_req_o_ready` in 1: downstream read ready.
- `mem_req_o_bits_idx` out `SLT_W`: tag, equal to the slot number.
- `mem_req_o_bits_mcn` out `MCN_W`: line number read.
- `mem_res_i_valid` in 1: memory response valid.
- `mem_res_i_ready` out 1: memory response ready; tied to 1.
- `mem_res_i_bits_idx` in `SLT_W`: slot tag of the response.
- `mem_res_i_bits_data` in `DAT_W`: returned line.
- `busy_o` out 1: high when any slot is not IDLE.

## Operation
Each slot holds: `st` in {IDLE, PEND, ISSD, RESP}, `mcn`, waiter mask `wt[TTW_N]`, and a `DAT_W` data buffer.
- Request fire means `req_i_valid & req_i_ready`. `req_i_ready` is high when any slot is IDLE in registered state. It does not depend on the request payload.
- Merge on fire:
  - If a slot in PEND or ISSD has `mcn == req_i_bits_mcn`, set `wt[idx]` in that slot. No new slot is allocated.
  - RESP slots are never merge targets.
- Allocate on fire when there is no merge: take the lowest-numbered IDLE slot. It goes to PEND, with `mcn` latched and `wt` set to one-hot `idx`.
- Issue: `mem_req_o_valid` is high when any slot is PEND. The issuing slot is the lowest-numbered PEND slot. On `mem_req_o_ready` the slot goes PEND→ISSD. Idx and mcn stay stable while valid is high and not ready.
- Memory response: on `mem_res_i_valid` the tagged slot, which must be ISSD, latches data and goes ISSD→RESP. A response to a non-ISSD slot is dropped and flagged by a bench assertion.
- Fan-out:
  - The selected slot is the lowest-numbered RESP slot.
  - `res_o_valid` is high. `res_o_bits_idx` is the lowest set bit of `wt`, and `res_o_bits_data` is the slot buffer.
  - On `res_o_ready` that bit clears. When `wt` becomes zero the slot goes to IDLE.
- `busy_o` is the OR of all slot states that are not IDLE.
- Reset: all slots IDLE, `wt` = 0. Output values under reset:
  - `req_i_ready` = 1.
  - `res_o_valid` = 0, `mem_req_o_valid` = 0, `busy_o` = 0.
  - `mem_res_i_ready` = 1.
  - All data and idx outputs = 0.
- Reset mid-operation: all in-flight state is discarded. Late memory responses arriving after reset hit IDLE slots and are dropped.

## Timing
- Request accepted in cycle t: `mem_req_o_valid` is high in t+1 at the earliest.
- Memory response in cycle u: `res_o_valid` is high in u+1 at the earliest. A slot with k waiters needs k cycles of `res_o_ready`.
- A slot freed in cycle t, by its last fan-out, can be allocated in t+1 and not in t. Free status is read from registered state.
- Request merge and memory response to the same slot in the same cycle: the slot goes to RESP and the merged `wt` bit is included.
- Request merge and PEND→ISSD issue in the same cycle: both take effect.
- Full: all slots busy gives `req_i_ready` = 0, even for a line that could have been merged.
- Walker indices are unique among outstanding requests. A duplicate `idx` is illegal and flagged by an assertion.
- All outputs come from registered state only. The exceptions are `res_o_bits_*` and `mem_req_o_bits_*`, which are muxed from slot registers by a priority select over registered state.

## Structure
- Shared package holds: the `ttw_t`, `slt_t`, `mcn_t` typedefs; the slot-state enum; `DAT_W`.
- Sub-module `ttw_mem_pri`: a parameterised lowest-set-bit priority encoder with valid and index outputs. It is used for allocation, issue, RESP select and waiter select.

## Test plan
- Single request: idx 1, mcn 0x1000. Then `mem_req_o` carries tag 0 and mcn 0x1000. Respond with data 0xA5…A5. Then exactly one `res_o` beat: idx 1, data 0xA5…A5. `busy_o` returns to 0.
- Merge: idx 0 and idx 2 both request mcn 0x40 before the response. Then only one `mem_req_o` is issued. Fan-out sends idx 0 then idx 2 on consecutive cycles.
- Full: 4 distinct mcn are accepted. Then `req_i_ready` = 0, even for a 5th request to a matching mcn. After the first fan-out completes, `req_i_ready` = 1 in the next cycle.
- Backpressure: hold `mem_req_o_ready` = 0 for 5 cycles. Idx and mcn stay stable. Hold `res_o_ready` = 0 and `res_o` stays stable.
- Out-of-order: responses for slots 2, 0, 1 in that order. Each waiter receives the data of its own line.
- Reset mid-flight: assert `reset` with 2 slots in ISSD, then send a late memory response. No `res_o_valid` is seen, and `busy_o` = 0 after reset.
